// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two Avalon-MM requester ports arbitrated round-robin onto
// a single-port synchronous RAM. One access is granted per cycle, combinationally
// in the request cycle; read data returns one cycle after the grant.
// Optional feature: define OCM_ARB_RANGE_CHECK_EN to block accesses at or above
// DEPTH. Such accesses never reach the RAM, reads return zero, and range_err
// stays set until reset.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2560
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // requester port 0
    input  logic [ADDR_W-1:0]     p0_address,
    input  logic [DATA_W/8-1:0]   p0_byteenable,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [DATA_W-1:0]     p0_writedata,
    output logic                  p0_waitrequest,
    output logic [DATA_W-1:0]     p0_readdata,
    output logic                  p0_readdatavalid,
    // requester port 1
    input  logic [ADDR_W-1:0]     p1_address,
    input  logic [DATA_W/8-1:0]   p1_byteenable,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [DATA_W-1:0]     p1_writedata,
    output logic                  p1_waitrequest,
    output logic [DATA_W-1:0]     p1_readdata,
    output logic                  p1_readdatavalid,
    // single-port RAM
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    // status
    output logic                  range_err
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Highest implemented word address plus one, widened by a bit so that a
    // DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic                req0;
    logic                req1;
    logic                grant;
    logic                rd_req;
    port_e               sel;
    port_e               prio;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W/8-1:0] sel_byteenable;
    logic [DATA_W-1:0]   sel_writedata;
    logic                sel_read;
    logic                sel_write;
    logic                addr_oor;
    logic                rdv0_q;
    logic                rdv1_q;
    logic                rd_zero_q;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // Choose the winner: the sole requester, or the port holding priority on a tie.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        sel = PORT0;
        if (req0 && req1) begin
            sel = prio;
        end else if (req1) begin
            sel = PORT1;
        end
    end

    // Nothing is granted while reset is held, which keeps both waitrequests high.
    assign grant = reset_n & (req0 | req1);

    assign sel_address    = (sel == PORT1) ? p1_address    : p0_address;
    assign sel_byteenable = (sel == PORT1) ? p1_byteenable : p0_byteenable;
    assign sel_writedata  = (sel == PORT1) ? p1_writedata  : p0_writedata;
    assign sel_read       = (sel == PORT1) ? p1_read       : p0_read;
    assign sel_write      = (sel == PORT1) ? p1_write      : p0_write;

    // Read and write together count as a write, so only a pure read returns data.
    assign rd_req = grant & sel_read & ~sel_write;

`ifdef OCM_ARB_RANGE_CHECK_EN
    logic range_err_q;

    assign addr_oor = ({1'b0, sel_address} >= DEPTH_LIM);

    // Sticky flag: set by any granted out-of-range access, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            range_err_q <= 1'b0;
        end else if (grant && addr_oor) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`else
    logic unused_depth;

    // Without range checking every address goes straight to the RAM.
    assign addr_oor     = 1'b0;
    assign range_err    = 1'b0;
    assign unused_depth = ^DEPTH_LIM;
`endif

    assign mem_address    = sel_address;
    assign mem_byteenable = sel_byteenable;
    assign mem_writedata  = sel_writedata;
    assign mem_chipselect = grant & ~addr_oor;
    assign mem_write      = grant & sel_write & ~addr_oor;
    assign mem_clken      = 1'b1;

    assign p0_waitrequest = ~(grant && (sel == PORT0));
    assign p1_waitrequest = ~(grant && (sel == PORT1));

    // Track the read-return slot and move round-robin priority on every grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio      <= PORT0;
            rdv0_q    <= 1'b0;
            rdv1_q    <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            rdv0_q    <= rd_req && (sel == PORT0);
            rdv1_q    <= rd_req && (sel == PORT1);
            rd_zero_q <= rd_req & addr_oor;
            if (grant) begin
                prio <= (sel == PORT0) ? PORT1 : PORT0;
            end
        end
    end

    assign p0_readdatavalid = rdv0_q;
    assign p1_readdatavalid = rdv1_q;
    assign p0_readdata      = (rdv0_q && !rd_zero_q) ? mem_readdata : '0;
    assign p1_readdata      = (rdv1_q && !rd_zero_q) ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM.
// Define OCM_ARB_RANGE_CHECK_EN for both files to exercise range checking.
module tb_onchip_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] p0_address, p1_address;
    logic [BW-1:0] p0_byteenable, p1_byteenable;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic [DW-1:0] p0_writedata, p1_writedata;
    logic          p0_waitrequest, p1_waitrequest;
    logic [DW-1:0] p0_readdata, p1_readdata;
    logic          p0_readdatavalid, p1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_readdata;
    logic          range_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2560)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_address       (p0_address),
        .p0_byteenable    (p0_byteenable),
        .p0_read          (p0_read),
        .p0_write         (p0_write),
        .p0_writedata     (p0_writedata),
        .p0_waitrequest   (p0_waitrequest),
        .p0_readdata      (p0_readdata),
        .p0_readdatavalid (p0_readdatavalid),
        .p1_address       (p1_address),
        .p1_byteenable    (p1_byteenable),
        .p1_read          (p1_read),
        .p1_write         (p1_write),
        .p1_writedata     (p1_writedata),
        .p1_waitrequest   (p1_waitrequest),
        .p1_readdata      (p1_readdata),
        .p1_readdatavalid (p1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .range_err        (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 4096 words so unchecked high addresses still land somewhere.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
        p0_address = '0; p1_address = '0;
        p0_byteenable = '1; p1_byteenable = '1;
        p0_writedata = '0; p1_writedata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
    endtask

    // Single-requester write on the chosen port; completes in one cycle.
    task automatic do_write(input int port, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [BW-1:0] be);
        if (port == 0) begin
            p0_address = addr; p0_writedata = data; p0_byteenable = be; p0_write = 1'b1;
        end else begin
            p1_address = addr; p1_writedata = data; p1_byteenable = be; p1_write = 1'b1;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        p0_read = 1'b1;
        p1_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b11)
            $display("FAIL reset_waitrequest: got %b expected 11", {p0_waitrequest, p1_waitrequest});
        else pass_cnt++;
        total_cnt++;
        if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00)
            $display("FAIL reset_readdatavalid: got %b expected 00", {p0_readdatavalid, p1_readdatavalid});
        else pass_cnt++;
        total_cnt++;
        if ({p0_readdata, p1_readdata} !== 64'h0)
            $display("FAIL reset_readdata: got %h expected 0", {p0_readdata, p1_readdata});
        else pass_cnt++;
        total_cnt++;
        if ({mem_chipselect, mem_write, range_err, mem_clken} !== 4'b0001)
            $display("FAIL reset_mem_ctrl: got %b expected 0001", {mem_chipselect, mem_write, range_err, mem_clken});
        else pass_cnt++;
        idle_inputs();
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_write_read();
        p0_address = 12'h010; p0_writedata = 32'hDEADBEEF; p0_byteenable = 4'hF; p0_write = 1'b1;
        #1;
        total_cnt++;
        if ({p0_waitrequest, p1_waitrequest, mem_chipselect, mem_write} !== 4'b0111)
            $display("FAIL wr_grant: got %b expected 0111", {p0_waitrequest, p1_waitrequest, mem_chipselect, mem_write});
        else pass_cnt++;
        total_cnt++;
        if ({mem_address, mem_writedata, mem_byteenable} !== {12'h010, 32'hDEADBEEF, 4'hF})
            $display("FAIL wr_mem_bus: got %h expected %h", {mem_address, mem_writedata, mem_byteenable}, {12'h010, 32'hDEADBEEF, 4'hF});
        else pass_cnt++;
        tick();
        idle_inputs();
        p0_address = 12'h010; p0_read = 1'b1;
        #1;
        total_cnt++;
        if ({p0_waitrequest, mem_chipselect, mem_write} !== 3'b010)
            $display("FAIL rd_grant: got %b expected 010", {p0_waitrequest, mem_chipselect, mem_write});
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if ({p0_readdatavalid, p1_readdatavalid} !== 2'b10)
            $display("FAIL rd_valid: got %b expected 10", {p0_readdatavalid, p1_readdatavalid});
        else pass_cnt++;
        total_cnt++;
        if (p0_readdata !== 32'hDEADBEEF)
            $display("FAIL rd_data: got %h expected deadbeef", p0_readdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({p0_readdatavalid, p0_readdata} !== 33'h0)
            $display("FAIL rd_valid_one_cycle: got %h expected 0", {p0_readdatavalid, p0_readdata});
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_wait;
        logic [1:0] exp_valid;
        do_write(0, 12'h100, 32'h0A0A0A0A, 4'hF);
        do_write(1, 12'h200, 32'h1B1B1B1B, 4'hF);
        apply_reset();
        p0_address = 12'h100; p0_read = 1'b1;
        p1_address = 12'h200; p1_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_wait  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_valid = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b01);
            total_cnt++;
            if ({p0_waitrequest, p1_waitrequest} !== exp_wait)
                $display("FAIL rr_grant cycle %0d: got %b expected %b", i, {p0_waitrequest, p1_waitrequest}, exp_wait);
            else pass_cnt++;
            total_cnt++;
            if ({p0_readdatavalid, p1_readdatavalid} !== exp_valid)
                $display("FAIL rr_valid cycle %0d: got %b expected %b", i, {p0_readdatavalid, p1_readdatavalid}, exp_valid);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if ((i % 2 == 1 && p0_readdata !== 32'h0A0A0A0A) || (i % 2 == 0 && p1_readdata !== 32'h1B1B1B1B))
                    $display("FAIL rr_data cycle %0d: got %h/%h", i, p0_readdata, p1_readdata);
                else pass_cnt++;
            end
            tick();
        end
        idle_inputs();
        #1;
        total_cnt++;
        if ({p0_readdatavalid, p1_readdatavalid, p1_readdata} !== {2'b01, 32'h1B1B1B1B})
            $display("FAIL rr_last: got %h expected %h", {p0_readdatavalid, p1_readdatavalid, p1_readdata}, {2'b01, 32'h1B1B1B1B});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_byte_enable();
        do_write(0, 12'h020, 32'hAABBCCDD, 4'hF);
        do_write(1, 12'h020, 32'h11223344, 4'b0011);
        p1_address = 12'h020; p1_read = 1'b1;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if ({p1_readdatavalid, p1_readdata} !== {1'b1, 32'hAABB3344})
            $display("FAIL byte_enable: got %h expected %h", {p1_readdatavalid, p1_readdata}, {1'b1, 32'hAABB3344});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_read_write_both();
        p1_address = 12'h030; p1_writedata = 32'h00000055; p1_read = 1'b1; p1_write = 1'b1;
        #1;
        total_cnt++;
        if ({p1_waitrequest, mem_chipselect, mem_write} !== 3'b011)
            $display("FAIL rw_as_write: got %b expected 011", {p1_waitrequest, mem_chipselect, mem_write});
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00)
            $display("FAIL rw_no_valid: got %b expected 00", {p0_readdatavalid, p1_readdatavalid});
        else pass_cnt++;
    endtask

    task automatic test_idle_pointer();
        apply_reset();
        do_write(0, 12'h040, 32'h1, 4'hF);
        repeat (3) tick();
        p0_read = 1'b1; p1_read = 1'b1;
        #1;
        total_cnt++;
        if ({p0_waitrequest, p1_waitrequest, mem_chipselect} !== 3'b101)
            $display("FAIL idle_keeps_ptr: got %b expected 101", {p0_waitrequest, p1_waitrequest, mem_chipselect});
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if ({mem_chipselect, p0_waitrequest, p1_waitrequest} !== 3'b011)
            $display("FAIL no_grant_idle: got %b expected 011", {mem_chipselect, p0_waitrequest, p1_waitrequest});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_discard();
        p0_address = 12'h010; p0_read = 1'b1;
        #1;
        total_cnt++;
        if (p0_waitrequest !== 1'b0)
            $display("FAIL discard_grant: got %b expected 0", p0_waitrequest);
        else pass_cnt++;
        tick();
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({p0_readdatavalid, p0_readdata, p0_waitrequest, p1_waitrequest, mem_chipselect, mem_write, range_err} !== {1'b0, 32'h0, 5'b11000})
            $display("FAIL discard_reset_outputs: got %h expected %h",
                     {p0_readdatavalid, p0_readdata, p0_waitrequest, p1_waitrequest, mem_chipselect, mem_write, range_err}, {1'b0, 32'h0, 5'b11000});
        else pass_cnt++;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00)
                $display("FAIL discard_no_valid %0d: got %b expected 00", i, {p0_readdatavalid, p1_readdatavalid});
            else pass_cnt++;
        end
    endtask

    task automatic test_range();
        logic        exp_cs;
        logic        exp_err;
        logic [31:0] exp_data;
`ifdef OCM_ARB_RANGE_CHECK_EN
        exp_cs = 1'b0; exp_err = 1'b1; exp_data = 32'h0;
`else
        exp_cs = 1'b1; exp_err = 1'b0; exp_data = 32'h12345678;
`endif
        p0_address = 12'hA00; p0_writedata = 32'h12345678; p0_write = 1'b1;
        #1;
        total_cnt++;
        if ({p0_waitrequest, mem_chipselect, mem_write} !== {1'b0, exp_cs, exp_cs})
            $display("FAIL range_write: got %b expected %b", {p0_waitrequest, mem_chipselect, mem_write}, {1'b0, exp_cs, exp_cs});
        else pass_cnt++;
        tick();
        idle_inputs();
        p0_address = 12'hA00; p0_read = 1'b1;
        #1;
        total_cnt++;
        if ({mem_chipselect, range_err} !== {exp_cs, exp_err})
            $display("FAIL range_read_cs: got %b expected %b", {mem_chipselect, range_err}, {exp_cs, exp_err});
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if ({p0_readdatavalid, p0_readdata} !== {1'b1, exp_data})
            $display("FAIL range_read_data: got %h expected %h", {p0_readdatavalid, p0_readdata}, {1'b1, exp_data});
        else pass_cnt++;
        repeat (2) tick();
        total_cnt++;
        if (range_err !== exp_err)
            $display("FAIL range_err_sticky: got %b expected %b", range_err, exp_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_byte_enable();
        test_read_write_both();
        test_idle_pointer();
        test_reset_discard();
        test_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
